// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel front-panel input conditioner.
// Each channel is polarity-adjusted, synchronised, debounced, then
// turned into a clean level plus one-cycle rise/fall/hold pulses.
module button_conditioner #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              DB_CYCLES   = 1000000,
  parameter int              HOLD_CYCLES = 100000000,
  parameter logic [N_CH-1:0] INVERT      = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] hold_o
);

  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sample_s;
    logic [DB_W-1:0]        cnt_r;
    logic [DB_W-1:0]        cnt_nxt_s;
    logic                   level_r;
    logic                   level_nxt_s;
    logic                   rise_r;
    logic                   fall_r;

    assign sample_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain; inversion is applied before the first flop only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], btn_i[c] ^ INVERT[c]};
      end
    end

    // Debounce next-state: count consecutive mismatches, flip level on the last.
    always_comb begin
      level_nxt_s = level_r;
      cnt_nxt_s   = '0;
      if (sample_s == level_r) begin
        level_nxt_s = level_r;
        cnt_nxt_s   = '0;
      end else if (cnt_r == DB_MAX) begin
        level_nxt_s = sample_s;
        cnt_nxt_s   = '0;
      end else begin
        level_nxt_s = level_r;
        cnt_nxt_s   = cnt_r + DB_W'(1);
      end
    end

    // Debounced level, counter and the registered edge pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r   <= '0;
        level_r <= 1'b0;
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else begin
        cnt_r   <= cnt_nxt_s;
        level_r <= level_nxt_s;
        rise_r  <= level_nxt_s & ~level_r;
        fall_r  <= ~level_nxt_s & level_r;
      end
    end

    assign level_o[c] = level_r;
    assign rise_o[c]  = rise_r;
    assign fall_o[c]  = fall_r;

    if (HOLD_CYCLES > 0) begin : g_hold
      localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

      logic [HOLD_W-1:0] hcnt_r;
      logic              fired_r;
      logic              hold_r;

      // Long-press timer: saturates at HOLD_MAX and fires once per press.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hcnt_r  <= '0;
          fired_r <= 1'b0;
          hold_r  <= 1'b0;
        end else if (!level_nxt_s) begin
          // Level low or falling now: the press is over, re-arm.
          hcnt_r  <= '0;
          fired_r <= 1'b0;
          hold_r  <= 1'b0;
        end else if (!level_r) begin
          // Level rising on this edge: timing starts next cycle.
          hcnt_r  <= '0;
          fired_r <= 1'b0;
          hold_r  <= 1'b0;
        end else if (hcnt_r == HOLD_MAX) begin
          hcnt_r  <= hcnt_r;
          fired_r <= 1'b1;
          hold_r  <= ~fired_r;
        end else begin
          hcnt_r  <= hcnt_r + HOLD_W'(1);
          fired_r <= fired_r;
          hold_r  <= 1'b0;
        end
      end

      assign hold_o[c] = hold_r;
    end else begin : g_no_hold
      assign hold_o[c] = 1'b0;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner (N_CH=4, SYNC=2, DB=4, HOLD=10, INVERT=4'b0100).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_i;
  logic [3:0] level_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic [3:0] hold_o;

  int vectors     = 0;
  int miscompares = 0;

  button_conditioner #(
    .N_CH        (4),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4),
    .HOLD_CYCLES (10),
    .INVERT      (4'b0100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .hold_o  (hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] h);
    chk({tag, ".level"}, level_o, l);
    chk({tag, ".rise"},  rise_o,  r);
    chk({tag, ".fall"},  fall_o,  f);
    chk({tag, ".hold"},  hold_o,  h);
  endtask

  initial begin
    // 1. Reset with every raw input high.
    rst   = 1'b1;
    btn_i = 4'b1111;
    cyc(3);
    chk_out("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Release into idle (ch2 idle is raw 1 because it is inverted).
    btn_i = 4'b0100;
    rst   = 1'b0;
    cyc(8);
    chk_out("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 2. ch1 press; level rises after edge k+5.
    btn_i[1] = 1'b1;
    cyc(5);
    chk_out("ch1_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("ch1_rise", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("ch1_after", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

    // 4a. Hold pulse exactly 10 cycles after the rise, once only.
    cyc(8);
    chk_out("ch1_hold_pre", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("ch1_hold", 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      chk("ch1_hold_once", hold_o, 4'b0000);
    end

    // 3. ch0 bounce 1,1,1,0 never reaches four consecutive samples.
    for (int i = 0; i < 16; i++) begin
      btn_i[0] = ((i % 4) != 3) ? 1'b1 : 1'b0;
      cyc(1);
      chk_out("ch0_glitch", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    end
    btn_i[0] = 1'b1;
    cyc(5);
    chk_out("ch0_pre", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("ch0_rise", 4'b0011, 4'b0001, 4'b0000, 4'b0000);

    // 4b. Release ch1: fall 5 edges later.
    btn_i[1] = 1'b0;
    cyc(5);
    chk_out("ch1_fall_pre", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("ch1_fall", 4'b0001, 4'b0000, 4'b0010, 4'b0000);
    cyc(1);
    chk_out("ch1_fall_after", 4'b0001, 4'b0000, 4'b0000, 4'b0000);

    // ch0 has now been high 7 cycles; its hold lands 10 after its rise.
    cyc(2);
    chk("ch0_hold_pre", hold_o, 4'b0000);
    cyc(1);
    chk_out("ch0_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    cyc(1);
    chk("ch0_hold_after", hold_o, 4'b0000);

    // 4c. Re-press ch1: a second hold for the new press.
    btn_i[1] = 1'b1;
    cyc(5);
    chk("ch1_repress_pre", level_o, 4'b0001);
    cyc(1);
    chk_out("ch1_repress", 4'b0011, 4'b0010, 4'b0000, 4'b0000);
    cyc(9);
    chk("ch1_rehold_pre", hold_o, 4'b0000);
    cyc(1);
    chk_out("ch1_rehold", 4'b0011, 4'b0000, 4'b0000, 4'b0010);
    cyc(1);
    chk("ch1_rehold_after", hold_o, 4'b0000);

    // 5. ch2 is active-low: driving 0 is a press.
    btn_i[2] = 1'b0;
    cyc(5);
    chk("ch2_pre", level_o, 4'b0011);
    cyc(1);
    chk_out("ch2_rise", 4'b0111, 4'b0100, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("ch2_after", 4'b0111, 4'b0000, 4'b0000, 4'b0000);

    // 6. ch3 press, reset while its debounce count is 2.
    btn_i[3] = 1'b1;
    cyc(4);
    chk_out("ch3_counting", 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(3);
    chk_out("rst_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // All four channels are still pressed at release: fresh presses.
    rst = 1'b0;
    cyc(5);
    chk_out("post_rst_pre", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("post_rst_rise", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("post_rst_after", 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    // Release everything together: simultaneous falls, no hold.
    btn_i = 4'b0100;
    cyc(5);
    chk_out("all_fall_pre", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    cyc(1);
    chk_out("all_fall", 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    cyc(1);
    chk_out("all_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised, multi-channel successor to the plain two-flop input synchronizer used on the front-panel controls (reset, record, play, number).
- Each channel passes through these stages in order:
  - optional polarity inversion;
  - a configurable-depth synchronizer chain;
  - a counter-based debouncer;
  - edge and long-press detection.
- Outputs are a clean level plus single-cycle rise, fall and hold pulses, so the recorder control FSM needs no extra edge logic.

Parameters:
- N_CH, 4: number of independent channels (>=1).
- SYNC_STAGES, 2: synchronizer flops per channel (>=2).
- DB_CYCLES, 1000000: consecutive mismatching samples required before the debounced level changes (>=1). A value of 1 means no filtering.
- HOLD_CYCLES, 100000000: cycles of continuous debounced-high before hold_o pulses. A value of 0 disables hold detection.
- INVERT, {N_CH{1'b0}}: per-channel mask. A 1 inverts that raw input before the sync chain, for active-low buttons.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_i  input  N_CH  raw asynchronous button inputs.
- level_o  output  N_CH  debounced level, active-high after INVERT.
- rise_o  output  N_CH  one-cycle pulse when level_o goes 0->1.
- fall_o  output  N_CH  one-cycle pulse when level_o goes 1->0.
- hold_o  output  N_CH  one-cycle pulse once per press after HOLD_CYCLES of high level.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to 0 immediately and holds them while rst=1:
  - sync flops, level, debounce counters, hold counters and hold-fired flags;
  - level_o, rise_o, fall_o, hold_o.
- Sync: x = btn_i[c] ^ INVERT[c] feeds a chain of SYNC_STAGES flops; s = last stage. No logic between stages.
- Debounce, per channel, evaluated every edge:
  - s == level: cnt <= 0.
  - s != level and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s != level and cnt == DB_CYCLES-1: level <= s, cnt <= 0.
  - Counter width is $clog2(DB_CYCLES) bits, minimum 1.
- Latency: input stable from before edge k flips level_o after edge k+SYNC_STAGES+DB_CYCLES-1. Example: SYNC=2, DB=4 gives edge k+5.
- Glitches: any return of s to level before DB_CYCLES consecutive mismatches discards the count. A glitch shorter than DB_CYCLES synchronized samples never reaches level_o.
- Edge pulses:
  - rise_o/fall_o are registered and asserted in the same cycle level_o changes, for exactly one cycle.
  - They are never both high on one channel, and never high without a level_o change.
- Hold:
  - While level=1, hcnt increments and saturates.
  - On the edge hcnt reaches HOLD_CYCLES-1 with the fired flag clear, hold_o pulses one cycle and the fired flag sets.
  - The fired flag and hcnt clear when level falls. A single press yields at most one hold_o.
  - HOLD_CYCLES=0: hold_o is tied to 0 and no counter is built.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation aborts any in-progress debounce or hold count with no pulse emitted. If an input is still asserted at reset release, it is treated as a fresh press: rise_o follows after the full latency.
- All outputs are registered; no combinational path from btn_i.

Test Plan (bench params: N_CH=4, SYNC_STAGES=2, DB_CYCLES=4, HOLD_CYCLES=10, INVERT=4'b0100):
1. rst=1, btn_i=4'b1111 -> level_o, rise_o, fall_o, hold_o all 0 during reset; ch2 inverted idle 0 stays 0.
2. Release rst, btn_i[1] 0->1 before edge k, held -> level_o[1]=1 after edge k+5; rise_o[1]=1 for exactly that one cycle; other channels unchanged.
3. btn_i[0] pattern 1,1,1,0,1,1,1,0 repeated -> level_o[0] stays 0, no pulses; then held 1 -> level_o[0]=1 after 4 consecutive synchronized high samples.
4. Keep btn_i[1] high -> hold_o[1] pulses once exactly 10 cycles after level_o[1] rose, never again while held. Release -> fall_o[1] one pulse 5 edges later. Re-press and hold -> hold_o[1] fires again.
5. btn_i[2] driven 0 (active-low press) -> level_o[2]=1, rise_o[2] pulse, per rule 2 timing.
6. btn_i[3] high, assert rst when debounce cnt=2 -> all outputs 0. Release rst with btn still high -> rise_o[3] only after full SYNC+DB latency from release.
